axi4_mm2s_scheduler: RTL and testbench
======================================

// Module: axi4_mm2s_scheduler
// PURPOSE
//  Shares one axi4_full_to_stream (MM2S) engine among NUM_REQ requesters. Each requester posts a job:
//  a start address plus a count of full bursts. Jobs are granted round-robin. A job is sequenced as
//  back-to-back engine reads at incrementing addresses. The block also drives the engine's
//  sw_reset/sw_reset_ok abort handshake. It sits between the control/register logic and the engine.
// PARAMETERS
//  NUM_REQ        4      number of requesters (2..8)
//  ADDR_WIDTH     32     engine read_address width
//  CNT_WIDTH      16     width of per-job burst count
//  BURST_BYTES    1024   address stride per engine read (burst_len * data_bytes, power of 2)
//  TIMEOUT_CYCLES 65535  watchdog limit per engine read (used only when MM2S_SCHED_WDOG_EN is defined)
// PORTS
//  ACLK              in   1                     clock
//  ARESETN           in   1                     synchronous reset, active-low
//  req_valid         in   NUM_REQ               job pending per requester
//  req_addr          in   NUM_REQ*ADDR_WIDTH    start address; slice i belongs to requester i
//  req_nbursts       in   NUM_REQ*CNT_WIDTH     number of bursts; slice i belongs to requester i
//  req_ready         out  NUM_REQ               1-cycle accept pulse, one-hot
//  req_done          out  NUM_REQ               1-cycle completion pulse, one-hot
//  req_err           out  NUM_REQ               1-cycle abort/timeout pulse, one-hot
//  abort             in   1                     abort the current job
//  eng_read_address  out  ADDR_WIDTH            to engine read_address
//  eng_start_read    out  1                     to engine start_read
//  eng_output_idle   in   1                     from engine output_idle
//  eng_sw_reset      out  1                     to engine sw_reset
//  eng_sw_reset_ok   in   1                     from engine sw_reset_ok
//  busy              out  1                     state != IDLE
//  grant_id          out  $clog2(NUM_REQ)       index of the current/last granted requester
// BEHAVIOUR
//  Reset values: all outputs 0, rr_ptr=0, state=IDLE.
//  States: IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE, NEXT, DONE, ABORT, DRAIN.
//  IDLE: if eng_output_idle and any req_valid, grant the first valid index at or after rr_ptr (cyclic).
//    Same cycle: latch addr/nbursts into cur_addr/remaining and set grant_id. Next cycle: pulse req_ready[g].
//    If nbursts==0, go to DONE; otherwise go to LAUNCH.
//  LAUNCH: eng_start_read=1 for exactly 1 cycle, with eng_read_address=cur_addr (held stable until the next LAUNCH).
//    Then go to WAIT_BUSY.
//  WAIT_BUSY: wait for eng_output_idle==0, then go to WAIT_IDLE.
//  WAIT_IDLE: wait for eng_output_idle==1, then go to NEXT.
//  NEXT: cur_addr += BURST_BYTES, wrapping modulo 2^ADDR_WIDTH; remaining -= 1.
//    If remaining becomes 0, go to DONE; otherwise go to LAUNCH.
//  DONE: pulse req_done[g] for 1 cycle; rr_ptr = (g+1) mod NUM_REQ; go to IDLE.
//  Minimum gap between consecutive eng_start_read pulses within one job: 4 cycles plus the engine read time.
//  abort=1 in LAUNCH, WAIT_BUSY, WAIT_IDLE or NEXT: go to ABORT. Abort has priority over a same-cycle transition.
//    abort in IDLE or DONE is ignored.
//  ABORT: hold eng_sw_reset=1 until eng_sw_reset_ok==1. Then drop eng_sw_reset and go to DRAIN.
//  DRAIN: wait for eng_sw_reset_ok==0 and eng_output_idle==1, then pulse req_err[g] and go to IDLE.
//    req_done is not pulsed for an aborted job. rr_ptr advances past g.
//  req_valid deasserted after acceptance has no effect. A requester re-raising req_valid the cycle after
//    req_done is not re-granted if any other requester is valid.
//  Only one of req_ready/req_done/req_err is high per cycle, and only for bit g.
//  Reset mid-job: all state is cleared immediately. No pulses are emitted for the lost job.
// CONFIGURATION
//  MM2S_SCHED_WDOG_EN defined: a counter is cleared on each LAUNCH and increments in WAIT_BUSY/WAIT_IDLE.
//    Reaching TIMEOUT_CYCLES forces ABORT, identical to abort=1, and req_err[g] ends the job.
//  MM2S_SCHED_WDOG_EN undefined: the counter and TIMEOUT_CYCLES logic are absent; waits are unbounded.
// TESTING
//  1. req_valid=4'b0001, addr=0x1000, nbursts=3 -> 3 start pulses at 0x1000/0x1400/0x1800, then one req_done[0].
//  2. req_valid=4'b1011 held -> grant order 0,1,3,0,... ; each req_ready precedes its req_done.
//  3. nbursts=0 on req 2 -> req_ready[2], then req_done[2] within 2 cycles, no eng_start_read.
//  4. addr=0xFFFFFC00, nbursts=2 -> addresses 0xFFFFFC00 then 0x00000000.
//  5. abort raised in WAIT_IDLE of burst 2 of 4 -> eng_sw_reset held until ok, req_err[g], no req_done[g],
//     next requester granted.
//  6. MM2S_SCHED_WDOG_EN, TIMEOUT_CYCLES=100, engine never goes idle -> ABORT at 100 cycles, req_err pulsed.
//     ARESETN=0 mid-job -> all outputs return to 0.

Source files
------------

// File: rtl/axi4_mm2s_scheduler.sv
// axi4_mm2s_scheduler
//   Round-robin job scheduler in front of a single axi4_full_to_stream (MM2S)
//   engine. Each requester posts {start address, burst count}; a granted job is
//   issued as back-to-back engine reads at BURST_BYTES strides. An abort drives
//   the engine's sw_reset / sw_reset_ok handshake and ends the job with req_err.
//   Optional feature: define MM2S_SCHED_WDOG_EN to add a per-read watchdog that
//   aborts the job after TIMEOUT_CYCLES wait cycles.
//   Clock ACLK, synchronous active-low reset ARESETN.

// Per-requester pulse lane: turns scheduler-wide event strobes into the
// registered one-hot req_ready/req_done/req_err bits for one requester.
module axi4_mm2s_scheduler_lane (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic hit_new,   // this lane is the one being granted now
  input  logic hit_cur,   // this lane owns the current/last job
  input  logic ev_ready,
  input  logic ev_done,
  input  logic ev_err,
  output logic ready,
  output logic done,
  output logic err
);
  // Registered single-cycle pulses
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ready <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      ready <= ev_ready && hit_new;
      done  <= ev_done  && hit_cur;
      err   <= ev_err   && hit_cur;
    end
  end
endmodule

module axi4_mm2s_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int BURST_BYTES    = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]    req_nbursts,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              req_done,
  output logic [NUM_REQ-1:0]              req_err,
  input  logic                            abort,
  output logic [ADDR_WIDTH-1:0]           eng_read_address,
  output logic                            eng_start_read,
  input  logic                            eng_output_idle,
  output logic                            eng_sw_reset,
  input  logic                            eng_sw_reset_ok,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE, NEXT, DONE, ABORT, DRAIN
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr, addr_inc, pick_addr;
  logic [CNT_WIDTH-1:0]  remaining, pick_nb;
  logic [IDW-1:0]        rr_ptr, pick_id, rr_after_g;
  logic                  pick_vld, grant, in_job, kill, wdog_to;
  logic                  ev_done, ev_err;

  // First valid requester at or after rr_ptr, searching cyclically
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(idx);
      end
    end
  end

  assign pick_addr  = req_addr[int'(pick_id)*ADDR_WIDTH +: ADDR_WIDTH];
  assign pick_nb    = req_nbursts[int'(pick_id)*CNT_WIDTH +: CNT_WIDTH];
  assign grant      = (state == IDLE) && eng_output_idle && pick_vld;
  assign in_job     = (state == LAUNCH) || (state == WAIT_BUSY) ||
                      (state == WAIT_IDLE) || (state == NEXT);
  // Abort (or watchdog) wins over any same-cycle transition
  assign kill       = in_job && (abort || wdog_to);
  // Stride wraps naturally at the address width
  assign addr_inc   = cur_addr + ADDR_WIDTH'(BURST_BYTES);
  assign rr_after_g = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
  assign ev_done    = (state == DONE);
  assign ev_err     = (state == DRAIN) && (state_nxt == IDLE);

`ifdef MM2S_SCHED_WDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wdog_cnt;
  logic           waiting;

  assign waiting = (state == WAIT_BUSY) || (state == WAIT_IDLE);
  // Fires on the TIMEOUT_CYCLES-th wait cycle of one engine read
  assign wdog_to = waiting && (wdog_cnt >= WDW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: cleared at each launch, counts engine wait cycles
  always_ff @(posedge ACLK) begin
    if (!ARESETN || state == LAUNCH) wdog_cnt <= '0;
    else if (waiting && !wdog_to)    wdog_cnt <= wdog_cnt + 1'b1;
  end
`else
  assign wdog_to = 1'b0;
`endif

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = (pick_nb == '0) ? DONE : LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!eng_output_idle) state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (eng_output_idle)  state_nxt = NEXT;
      NEXT:      state_nxt = (remaining == CNT_WIDTH'(1)) ? DONE : LAUNCH;
      DONE:      state_nxt = IDLE;
      ABORT:     if (eng_sw_reset_ok) state_nxt = DRAIN;
      DRAIN:     if (!eng_sw_reset_ok && eng_output_idle) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (kill) state_nxt = ABORT;
  end

  // State-decoded outputs
  always_comb begin
    eng_start_read = (state == LAUNCH);
    eng_sw_reset   = (state == ABORT);
    busy           = (state != IDLE);
  end

  // Job datapath: grant capture, address/count stepping, round-robin pointer
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cur_addr         <= '0;
      remaining        <= '0;
      grant_id         <= '0;
      rr_ptr           <= '0;
      eng_read_address <= '0;
    end else begin
      if (grant) begin
        grant_id  <= pick_id;
        cur_addr  <= pick_addr;
        remaining <= pick_nb;
        if (pick_nb != '0) eng_read_address <= pick_addr;
      end
      if (state == NEXT && !kill) begin
        cur_addr  <= addr_inc;
        remaining <= remaining - 1'b1;
        // Address only moves when the next read is launched
        if (state_nxt == LAUNCH) eng_read_address <= addr_inc;
      end
      if (ev_done || ev_err) rr_ptr <= rr_after_g;
    end
  end

  // One pulse lane per requester
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    axi4_mm2s_scheduler_lane u_lane (
      .ACLK     (ACLK),
      .ARESETN  (ARESETN),
      .hit_new  (pick_id == IDW'(i)),
      .hit_cur  (grant_id == IDW'(i)),
      .ev_ready (grant),
      .ev_done  (ev_done),
      .ev_err   (ev_err),
      .ready    (req_ready[i]),
      .done     (req_done[i]),
      .err      (req_err[i])
    );
  end

endmodule

// File: tb/tb_axi4_mm2s_scheduler.sv
// tb_axi4_mm2s_scheduler
//   Scoreboard bench: expected pulses and engine read addresses are queued when
//   jobs are posted and popped as the DUT produces them. A small behavioural
//   engine answers start_read and the sw_reset handshake.
//   Define MM2S_SCHED_WDOG_EN to include the watchdog scenario.
module tb_axi4_mm2s_scheduler;
  localparam int NR = 4, AW = 32, CW = 16, BB = 1024;
`ifdef MM2S_SCHED_WDOG_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 65535;
`endif
  localparam int EW = 3 * NR;

  logic              ACLK = 1'b0, ARESETN = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*CW-1:0]  req_nbursts = '0;
  logic [NR-1:0]     req_ready, req_done, req_err;
  logic              abort = 1'b0;
  logic [AW-1:0]     eng_read_address;
  logic              eng_start_read, eng_sw_reset, busy;
  logic              eng_output_idle = 1'b1, eng_sw_reset_ok = 1'b0;
  logic [1:0]        grant_id;

  int n_chk = 0, n_err = 0, cyc = 0, n_start = 0, last_start = -1;
  logic [EW-1:0] evq[$];
  logic [AW-1:0] adq[$];
  bit  auto_drop = 1'b1, hang = 1'b0;
  int  busy_len = 6;

  axi4_mm2s_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
                        .BURST_BYTES(BB), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req_valid(req_valid), .req_addr(req_addr),
    .req_nbursts(req_nbursts), .req_ready(req_ready), .req_done(req_done),
    .req_err(req_err), .abort(abort), .eng_read_address(eng_read_address),
    .eng_start_read(eng_start_read), .eng_output_idle(eng_output_idle),
    .eng_sw_reset(eng_sw_reset), .eng_sw_reset_ok(eng_sw_reset_ok),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 ACLK = ~ACLK;

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // kind: 2=ready, 1=done, 0=err; layout matches {req_ready,req_done,req_err}
  function automatic logic [EW-1:0] ev(input int kind, input int id);
    logic [EW-1:0] v;
    v = '0;
    v[kind*NR + id] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int id, input logic [AW-1:0] a, input int nb);
    req_addr[id*AW +: AW]    = a;
    req_nbursts[id*CW +: CW] = CW'(nb);
  endtask

  task automatic push_job(input int id, input logic [AW-1:0] a, input int nb);
    logic [AW-1:0] x;
    x = a;
    evq.push_back(ev(2, id));
    for (int k = 0; k < nb; k++) begin
      adq.push_back(x);
      x = x + AW'(BB);
    end
    evq.push_back(ev(1, id));
  endtask

  // which: 0 ready[id], 1 done[id], 2 err[id], 3 start_read, 4 sw_reset, 5 any ready
  task automatic wait_for(input int which, input int id, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge ACLK);
      case (which)
        0: seen = req_ready[id];
        1: seen = req_done[id];
        2: seen = req_err[id];
        3: seen = eng_start_read;
        4: seen = eng_sw_reset;
        default: seen = |req_ready;
      endcase
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && (evq.size() + adq.size()) != 0; i++) @(negedge ACLK);
    chk(tag, 64'(evq.size() + adq.size()), 64'd0);
    repeat (3) @(negedge ACLK);
  endtask

  // Behavioural engine
  initial begin
    int busy_left, sr_cnt;
    busy_left = 0;
    sr_cnt = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        eng_output_idle = 1'b1; eng_sw_reset_ok = 1'b0; busy_left = 0; sr_cnt = 0;
      end else if (eng_sw_reset) begin
        busy_left = 0;
        sr_cnt++;
        if (sr_cnt >= 3) eng_sw_reset_ok = 1'b1;
      end else if (eng_sw_reset_ok) begin
        eng_sw_reset_ok = 1'b0; eng_output_idle = 1'b1; sr_cnt = 0;
      end else if (eng_start_read) begin
        eng_output_idle = 1'b0;
        busy_left = hang ? 0 : busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) eng_output_idle = 1'b1;
      end
    end
  end

  // Requesters drop req_valid once accepted
  initial forever begin
    @(negedge ACLK);
    if (auto_drop) req_valid = req_valid & ~req_ready;
  end

  // Scoreboard monitor
  initial begin
    logic [EW-1:0] pv;
    forever begin
      @(negedge ACLK);
      if (ARESETN) begin
        pv = {req_ready, req_done, req_err};
        if (pv != '0) begin
          chk("pulse_onehot", 64'($countones(pv)), 64'd1);
          if (evq.size() == 0) chk("unexpected_pulse", 64'(pv), 64'd0);
          else                 chk("pulse", 64'(pv), 64'(evq.pop_front()));
        end
        if (eng_start_read) begin
          if (adq.size() == 0) chk("unexpected_start", 64'(eng_start_read), 64'd0);
          else                 chk("start_addr", 64'(eng_read_address), 64'(adq.pop_front()));
          if (last_start >= 0) chk("start_gap_ge4", 64'(cyc - last_start >= 4), 64'd1);
          last_start = cyc;
          n_start++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, g, hi;
    bit seen;
    repeat (3) @(negedge ACLK);
    chk("rst_pulses", 64'({req_ready, req_done, req_err}), 64'd0);
    chk("rst_ctl", 64'({eng_start_read, eng_sw_reset, busy}), 64'd0);
    chk("rst_addr", 64'(eng_read_address), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Held 1011 -> grants 0,1,3,0
    auto_drop = 1'b0;
    set_req(0, 32'h0001_0000, 1);
    set_req(1, 32'h0002_0000, 1);
    set_req(3, 32'h0003_0000, 1);
    push_job(0, 32'h0001_0000, 1);
    push_job(1, 32'h0002_0000, 1);
    push_job(3, 32'h0003_0000, 1);
    push_job(0, 32'h0001_0000, 1);
    req_valid = 4'b1011;
    for (int k = 0; k < 4; k++) wait_for(5, 0, "rr_ready");
    req_valid = '0;
    auto_drop = 1'b1;
    wait_drain("rr_drain");

    // Three bursts from 0x1000
    set_req(0, 32'h0000_1000, 3);
    push_job(0, 32'h0000_1000, 3);
    req_valid = 4'b0001;
    wait_drain("seq3_drain");
    chk("seq3_busy_after", 64'(busy), 64'd0);

    // Zero-burst job
    set_req(2, 32'h0000_5000, 0);
    s0 = n_start;
    push_job(2, 32'h0000_5000, 0);
    req_valid = 4'b0100;
    wait_for(0, 2, "zero_ready");
    g = 0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge ACLK);
      g++;
      seen = req_done[2];
    end
    chk("zero_done_within2", 64'(seen && g <= 2), 64'd1);
    chk("zero_no_start", 64'(n_start), 64'(s0));
    chk("zero_gid", 64'(grant_id), 64'd2);
    wait_drain("zero_drain");

    // Address wrap
    set_req(3, 32'hFFFF_FC00, 2);
    push_job(3, 32'hFFFF_FC00, 2);
    req_valid = 4'b1000;
    wait_drain("wrap_drain");

    // Abort in WAIT_IDLE of burst 2 of 4, then requester 2 follows
    set_req(1, 32'h0000_2000, 4);
    set_req(2, 32'h0000_9000, 1);
    evq.push_back(ev(2, 1));
    adq.push_back(32'h0000_2000);
    adq.push_back(32'h0000_2400);
    evq.push_back(ev(0, 1));
    push_job(2, 32'h0000_9000, 1);
    req_valid = 4'b0110;
    wait_for(3, 0, "abort_start1");
    wait_for(3, 0, "abort_start2");
    repeat (3) @(negedge ACLK);
    abort = 1'b1;
    @(negedge ACLK);
    abort = 1'b0;
    hi = 0; seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge ACLK);
      #1;
      if (eng_sw_reset) hi++;
      else if (hi > 0) seen = 1'b1;
    end
    chk("abort_sw_reset_seen", 64'(hi > 0), 64'd1);
    chk("abort_released", 64'(seen), 64'd1);
    chk("abort_held_until_ok", 64'(eng_sw_reset_ok), 64'd1);
    @(negedge ACLK);
    wait_drain("abort_drain");

`ifdef MM2S_SCHED_WDOG_EN
    // Engine never returns idle -> watchdog abort
    hang = 1'b1;
    set_req(0, 32'h0000_4000, 2);
    evq.push_back(ev(2, 0));
    adq.push_back(32'h0000_4000);
    evq.push_back(ev(0, 0));
    req_valid = 4'b0001;
    wait_for(3, 0, "wdog_start");
    s0 = cyc;
    wait_for(4, 0, "wdog_sw_reset");
    chk("wdog_gap", 64'((cyc - s0) >= TMO && (cyc - s0) <= TMO + 2), 64'd1);
    hang = 1'b0;
    wait_drain("wdog_drain");
`endif

    // Reset mid-job: everything clears, lost job emits nothing
    set_req(0, 32'h0000_8000, 4);
    evq.push_back(ev(2, 0));
    adq.push_back(32'h0000_8000);
    req_valid = 4'b0001;
    wait_for(3, 0, "mrst_start");
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b0;
    @(negedge ACLK);
    chk("mrst_pulses", 64'({req_ready, req_done, req_err}), 64'd0);
    chk("mrst_ctl", 64'({eng_start_read, eng_sw_reset, busy}), 64'd0);
    chk("mrst_addr", 64'(eng_read_address), 64'd0);
    chk("mrst_gid", 64'(grant_id), 64'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (5) @(negedge ACLK);
    chk("mrst_no_pulse", 64'({req_ready, req_done, req_err, eng_start_read}), 64'd0);

    // rr_ptr back at 0 after reset: 0 before 3
    set_req(0, 32'h0000_A000, 1);
    set_req(3, 32'h0000_B000, 1);
    push_job(0, 32'h0000_A000, 1);
    push_job(3, 32'h0000_B000, 1);
    req_valid = 4'b1001;
    wait_drain("mrst_rr_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
